// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequential RV32I/RV64I load/store unit. Computes the effective
//            address, byte enables, store-lane replication and load
//            sign/zero extension, and runs a request/response handshake
//            with a word-wide data memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_n_i           clock (rising edge), async active-low reset
//   req_*                    access request from decode (valid/ready)
//   mem_*                    word-addressed memory request + read response
//   rsp_*                    one-cycle completion / register write-back
//   exc_*                    one-cycle exception (cause, faulting address)
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN     defined: misaligned accesses trap (cause 0/1)
//                            undefined: offset is forced down to alignment
// ============================================================================
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_base_i,
  input  logic [XLEN-1:0]   req_offset_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_we_o,
  output logic [4:0]        rsp_rd_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              exc_valid_o,
  output logic [1:0]        exc_cause_o,
  output logic [XLEN-1:0]   exc_addr_o
);

  localparam int NB     = XLEN / 8;
  localparam int OFFS_W = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RSP  = 3'd3,
    S_EXC  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   ea_q, ea_d;
  logic [OFFS_W-1:0] off_q, off_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   ldata_q, ldata_d;
  logic [1:0]        cause_q, cause_d;

  // Request decode (combinational on the req_* inputs)
  logic [XLEN-1:0]   ea_w;
  logic [3:0]        size_w;
  logic [OFFS_W-1:0] off_raw_w, align_mask_w, off_w;
  logic [NB-1:0]     be_base_w, be_w;
  logic [XLEN-1:0]   wrep_w;
  logic              legal_w;
  logic              trap_mis_w;

  always_comb begin
    ea_w         = req_base_i + req_offset_i;
    size_w       = 4'd1 << req_funct3_i[1:0];
    off_raw_w    = ea_w[OFFS_W-1:0];
    align_mask_w = OFFS_W'(size_w - 4'd1);
    for (int i = 0; i < NB; i++) begin
      be_base_w[i] = (i < int'(size_w));
    end

    if (req_we_i) begin
      legal_w = !req_funct3_i[2] && ((req_funct3_i[1:0] != 2'b11) || (XLEN == 64));
    end else begin
      case (req_funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_w = 1'b1;
        3'b011, 3'b110:                         legal_w = (XLEN == 64);
        default:                                legal_w = 1'b0;
      endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    off_w      = off_raw_w;
    trap_mis_w = |(off_raw_w & align_mask_w);
`else
    // Without the trap, clear the low offset bits so the access is aligned
    off_w      = off_raw_w & ~align_mask_w;
    trap_mis_w = 1'b0;
`endif

    be_w = be_base_w << off_w;

    case (req_funct3_i[1:0])
      2'b00:   wrep_w = {NB{req_wdata_i[7:0]}};
      2'b01:   wrep_w = {(NB/2){req_wdata_i[15:0]}};
      2'b10:   wrep_w = {(NB/4){req_wdata_i[31:0]}};
      default: wrep_w = req_wdata_i;
    endcase
  end

  // Load extraction from the returned word, using captured offset/funct3
  logic [XLEN-1:0] rshift_w, lext_w;

  always_comb begin
    rshift_w = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  lext_w = XLEN'($signed(rshift_w[7:0]));
      3'b001:  lext_w = XLEN'($signed(rshift_w[15:0]));
      3'b010:  lext_w = XLEN'($signed(rshift_w[31:0]));
      3'b100:  lext_w = XLEN'(rshift_w[7:0]);
      3'b101:  lext_w = XLEN'(rshift_w[15:0]);
      3'b110:  lext_w = XLEN'(rshift_w[31:0]);
      default: lext_w = rshift_w;
    endcase
  end

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    ea_d     = ea_q;
    off_d    = off_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ldata_d  = ldata_q;
    cause_d  = cause_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          rd_d     = req_rd_i;
          ea_d     = ea_w;
          off_d    = off_w;
          be_d     = be_w;
          wdata_d  = wrep_w;
          ldata_d  = '0;
          // Illegal encoding takes priority over misalignment
          if (!legal_w) begin
            cause_d = 2'd2;
            state_d = S_EXC;
          end else if (trap_mis_w) begin
            cause_d = req_we_i ? 2'd1 : 2'd0;
            state_d = S_EXC;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          state_d = we_q ? S_RSP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          ldata_d = lext_w;
          state_d = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      ea_q     <= '0;
      off_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      ldata_q  <= '0;
      cause_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      ea_q     <= ea_d;
      off_q    <= off_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      ldata_q  <= ldata_d;
      cause_q  <= cause_d;
    end
  end

  // Outputs are qualified by state so idle channels read as zero
  logic in_req, in_rsp, in_exc;
  assign in_req = (state_q == S_REQ);
  assign in_rsp = (state_q == S_RSP);
  assign in_exc = (state_q == S_EXC);

  assign req_ready_o = (state_q == S_IDLE);
  assign mem_valid_o = in_req;
  assign mem_addr_o  = in_req ? (ea_q >> OFFS_W) : '0;
  assign mem_we_o    = in_req & we_q;
  assign mem_be_o    = in_req ? be_q : '0;
  assign mem_wdata_o = in_req ? wdata_q : '0;
  assign rsp_valid_o = in_rsp;
  assign rsp_we_o    = in_rsp & ~we_q;
  assign rsp_rd_o    = in_rsp ? rd_q : 5'd0;
  assign rsp_data_o  = (in_rsp && !we_q) ? ldata_q : '0;
  assign exc_valid_o = in_exc;
  assign exc_cause_o = in_exc ? cause_q : 2'd0;
  assign exc_addr_o  = in_exc ? ea_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit (XLEN=32). Expected memory
//            requests and responses are queued when a request is driven and
//            compared when the unit produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              req_valid_i, req_ready_o, req_we_i;
  logic [2:0]        req_funct3_i;
  logic [XLEN-1:0]   req_base_i, req_offset_i, req_wdata_i;
  logic [4:0]        req_rd_i;
  logic              mem_valid_o, mem_ready_i, mem_we_o;
  logic [XLEN-1:0]   mem_addr_o, mem_wdata_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              rsp_valid_o, rsp_we_o;
  logic [4:0]        rsp_rd_o;
  logic [XLEN-1:0]   rsp_data_o;
  logic              exc_valid_o;
  logic [1:0]        exc_cause_o;
  logic [XLEN-1:0]   exc_addr_o;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_base_i(req_base_i), .req_offset_i(req_offset_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rd_o(rsp_rd_o),
    .rsp_data_o(rsp_data_o), .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o),
    .exc_addr_o(exc_addr_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] data;
    int          c0;
    int          lat;
  } rsp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  rsp_exp_t rq[$];
  mem_exp_t mq[$];
  rsp_exp_t re;
  mem_exp_t me;

  function automatic rsp_exp_t mk_rsp(logic exc, logic [1:0] cause, logic [31:0] addr,
                                      logic ld, logic [4:0] rd, logic [31:0] data, int lat);
    rsp_exp_t e;
    e.exc = exc; e.cause = cause; e.addr = addr; e.ld = ld; e.rd = rd;
    e.data = data; e.c0 = 0; e.lat = lat;
    return e;
  endfunction

  function automatic mem_exp_t mk_mem(logic [31:0] addr, logic we, logic [3:0] be, logic [31:0] wd);
    mem_exp_t m;
    m.addr = addr; m.we = we; m.be = be; m.wdata = wd;
    return m;
  endfunction

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: ready stalls for stall_left REQ cycles; read data returns
  // rdelay cycles after the minimum one-cycle response.
  int          stall_left = 0;
  int          rdelay     = 0;
  int          pend       = 0;
  logic [31:0] rdata_next = '0;
  logic        r_vld, r_hs_ld;

  initial begin
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      r_vld   = mem_valid_o;
      r_hs_ld = mem_valid_o && mem_ready_i && !mem_we_o;
      #1;
      if (r_vld && stall_left > 0) stall_left--;
      mem_ready_i  = (stall_left == 0);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (r_hs_ld) pend = rdelay + 1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rdata_next;
        end
      end
    end
  end

  // Memory request monitor: checks every REQ cycle (stability while stalled)
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i && mem_valid_o) begin
      if (mq.size() == 0) begin
        check_eq("mem_unexpected", mem_valid_o, 1'b0);
      end else begin
        if (mem_ready_i) me = mq.pop_front();
        else             me = mq[0];
        check_eq("mem_addr", mem_addr_o, me.addr);
        check_eq("mem_we", mem_we_o, me.we);
        check_eq("mem_be", mem_be_o, me.be);
        if (me.we) check_eq("mem_wdata", mem_wdata_o, me.wdata);
      end
    end
  end

  // Response / exception monitor
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i && (rsp_valid_o || exc_valid_o)) begin
      if (rq.size() == 0) begin
        check_eq("rsp_unexpected", {rsp_valid_o, exc_valid_o}, 2'b00);
      end else begin
        re = rq.pop_front();
        check_eq("exc_valid", exc_valid_o, re.exc);
        check_eq("rsp_valid", rsp_valid_o, !re.exc);
        if (re.exc) begin
          check_eq("exc_cause", exc_cause_o, re.cause);
          check_eq("exc_addr", exc_addr_o, re.addr);
        end else begin
          check_eq("rsp_we", rsp_we_o, re.ld);
          if (re.ld) check_eq("rsp_rd", rsp_rd_o, re.rd);
          check_eq("rsp_data", rsp_data_o, re.data);
        end
        if (re.lat != 0) check_eq("latency", cyc - re.c0, re.lat);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                       input logic has_mem, input mem_exp_t m,
                       input logic has_rsp, input rsp_exp_t e);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) check_eq("ready_timeout", req_ready_o, 1'b1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_base_i   = base;
    req_offset_i = off;
    req_wdata_i  = wd;
    req_rd_i     = rd;
    e.c0 = cyc;
    if (has_mem) mq.push_back(m);
    if (has_rsp) rq.push_back(e);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 100) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    if (rq.size() != 0 || mq.size() != 0) begin
      check_eq("done_timeout", rq.size() + mq.size(), 0);
      rq.delete();
      mq.delete();
    end
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic has_mem, input mem_exp_t m,
                        input rsp_exp_t e);
    rdata_next = rdata;
    issue(we, f3, base, off, wd, rd, has_mem, m, 1'b1, e);
    wait_done();
  endtask

  mem_exp_t no_mem;

  initial begin
    no_mem       = mk_mem(32'h0, 1'b0, 4'h0, 32'h0);
    rst_n_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b000;
    req_base_i   = '0;
    req_offset_i = '0;
    req_wdata_i  = '0;
    req_rd_i     = 5'd0;
    repeat (3) @(negedge clk_i);

    check_eq("rst_req_ready", req_ready_o, 1'b1);
    check_eq("rst_mem_valid", mem_valid_o, 1'b0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("rst_rsp_data", rsp_data_o, 32'h0);
    check_eq("rst_exc_valid", exc_valid_o, 1'b0);
    check_eq("rst_exc_cause", exc_cause_o, 2'd0);
    rst_n_i = 1'b1;

    // LW 0x100+4
    do_txn(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF,
           1'b1, mk_mem(32'h41, 1'b0, 4'hF, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 3));
    // LB / LBU at 0x203
    do_txn(1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd6, 32'h80112233,
           1'b1, mk_mem(32'h80, 1'b0, 4'h8, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd6, 32'hFFFFFF80, 3));
    do_txn(1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd7, 32'h80112233,
           1'b1, mk_mem(32'h80, 1'b0, 4'h8, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd7, 32'h00000080, 3));
    // SH at 0x102 with memory stalling three cycles
    stall_left = 3;
    do_txn(1'b1, 3'b001, 32'h100, 32'h2, 32'h0000ABCD, 5'd0, 32'h0,
           1'b1, mk_mem(32'h40, 1'b1, 4'hC, 32'hABCDABCD),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5));
    // Misaligned LW / SW
`ifdef LSU_MISALIGN_TRAP_EN
    do_txn(1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd8, 32'h12345678,
           1'b0, no_mem, mk_rsp(1'b1, 2'd0, 32'h101, 1'b0, 5'd0, 32'h0, 1));
    do_txn(1'b1, 3'b010, 32'h100, 32'h2, 32'h11223344, 5'd0, 32'h0,
           1'b0, no_mem, mk_rsp(1'b1, 2'd1, 32'h102, 1'b0, 5'd0, 32'h0, 1));
`else
    do_txn(1'b0, 3'b010, 32'h100, 32'h1, 32'h0, 5'd8, 32'h12345678,
           1'b1, mk_mem(32'h40, 1'b0, 4'hF, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd8, 32'h12345678, 3));
    do_txn(1'b1, 3'b010, 32'h100, 32'h2, 32'h11223344, 5'd0, 32'h0,
           1'b1, mk_mem(32'h40, 1'b1, 4'hF, 32'h11223344),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2));
`endif
    // Illegal funct3 codes for XLEN=32
    do_txn(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 5'd9, 32'h0,
           1'b0, no_mem, mk_rsp(1'b1, 2'd2, 32'h300, 1'b0, 5'd0, 32'h0, 1));
    do_txn(1'b1, 3'b011, 32'h304, 32'h4, 32'h0, 5'd0, 32'h0,
           1'b0, no_mem, mk_rsp(1'b1, 2'd2, 32'h308, 1'b0, 5'd0, 32'h0, 1));
    do_txn(1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 5'd1, 32'h0,
           1'b0, no_mem, mk_rsp(1'b1, 2'd2, 32'h10, 1'b0, 5'd0, 32'h0, 1));
    do_txn(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 5'd0, 32'h0,
           1'b0, no_mem, mk_rsp(1'b1, 2'd2, 32'h20, 1'b0, 5'd0, 32'h0, 1));
    // LH / LHU at 0x106 via negative offset
    do_txn(1'b0, 3'b001, 32'h108, 32'hFFFFFFFE, 32'h0, 5'd10, 32'h80017FFF,
           1'b1, mk_mem(32'h41, 1'b0, 4'hC, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd10, 32'hFFFF8001, 3));
    do_txn(1'b0, 3'b101, 32'h108, 32'hFFFFFFFE, 32'h0, 5'd11, 32'h80017FFF,
           1'b1, mk_mem(32'h41, 1'b0, 4'hC, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd11, 32'h00008001, 3));
    // SB at 0x7, SW at 0x10, LB positive at 0x400
    do_txn(1'b1, 3'b000, 32'h0, 32'h7, 32'h123456A5, 5'd0, 32'h0,
           1'b1, mk_mem(32'h1, 1'b1, 4'h8, 32'hA5A5A5A5),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2));
    do_txn(1'b1, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 5'd0, 32'h0,
           1'b1, mk_mem(32'h4, 1'b1, 4'hF, 32'hCAFEF00D),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2));
    do_txn(1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 5'd12, 32'hFFFFFF7F,
           1'b1, mk_mem(32'h100, 1'b0, 4'h1, 32'h0),
           mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd12, 32'h0000007F, 3));

    // Reset while a load waits for read data; the late rvalid must be ignored
    rdelay = 4;
    rdata_next = 32'h55AA55AA;
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1,
          mk_mem(32'h0, 1'b0, 4'hF, 32'h0), 1'b0, mk_rsp(1'b0, 2'd0, 32'h0, 1'b1, 5'd13, 32'h0, 0));
    @(negedge clk_i);
    check_eq("wait_req_ready", req_ready_o, 1'b0);
    rst_n_i = 1'b0;
    #1;
    check_eq("midrst_req_ready", req_ready_o, 1'b1);
    check_eq("midrst_mem_valid", mem_valid_o, 1'b0);
    check_eq("midrst_rsp_valid", rsp_valid_o, 1'b0);
    check_eq("midrst_rsp_data", rsp_data_o, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check_eq("post_rst_req_ready", req_ready_o, 1'b1);
    check_eq("post_rst_queues", rq.size() + mq.size(), 0);
    rdelay = 0;

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential memory-access unit executing all RV32I/RV64I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW, plus LD/LWU/SD when XLEN=64).
- Sits between the instruction decoder and the data memory port. Computes the effective address, byte enables, write-lane replication and load sign/zero extension.
- Runs a request/response handshake with memory and returns write-back data for the register file.

Parameters:
- XLEN, 32, datapath and address width; legal values 32 or 64.
- NB, XLEN/8, bytes per memory word (derived, not overridable).
- OFFS_W, $clog2(NB), byte-offset bits within a word (derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  access request valid.
- req_ready_o  out  1  unit can accept a request (state IDLE).
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  instr[14:12] width/sign code.
- req_base_i  in  XLEN  rs1 value.
- req_offset_i  in  XLEN  sign-extended I or S immediate.
- req_wdata_i  in  XLEN  rs2 value (stores).
- req_rd_i  in  5  destination register (loads).
- mem_valid_o  out  1  memory request valid.
- mem_ready_i  in  1  memory accepts request.
- mem_addr_o  out  XLEN  word index = effective address >> OFFS_W.
- mem_we_o  out  1  memory write.
- mem_be_o  out  NB  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  XLEN  read data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_we_o  out  1  register-file write enable (1 for loads only).
- rsp_rd_o  out  5  destination register.
- rsp_data_o  out  XLEN  extended load data (0 for stores).
- exc_valid_o  out  1  one-cycle exception pulse.
- exc_cause_o  out  2  0 = load misaligned, 1 = store misaligned, 2 = illegal funct3.
- exc_addr_o  out  XLEN  faulting effective address.

Behaviour:
- Reset: asynchronous, active low. State goes to IDLE. All outputs are 0 except req_ready_o = 1. Reset mid-transaction abandons it; mem_rvalid_i arriving afterwards is ignored because rvalid is sampled only in WAIT.
- States: IDLE, REQ, WAIT, RSP, EXC. All outputs are registered or decoded from state and capture registers only.
- IDLE:
  - On req_valid_i && req_ready_o, capture all req_* fields and compute ea = req_base_i + req_offset_i, modulo 2^XLEN.
  - Illegal funct3 or misaligned access -> EXC. Otherwise -> REQ.
- REQ: mem_valid_o = 1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are held stable until mem_ready_i.
  - On handshake, a store -> RSP and a load -> WAIT.
- WAIT: on mem_rvalid_i, capture the extended data -> RSP. There is no timeout; the memory must respond.
- RSP: rsp_valid_o = 1 for exactly one cycle -> IDLE. No back-pressure on the rsp channel.
- EXC: exc_valid_o = 1 for one cycle with cause and address; no memory access is issued -> IDLE.
- Minimum latencies, with mem_ready_i high and rvalid one cycle after the handshake:
  - Load: accept at edge 0, mem_valid_o in cycle 1, rvalid in cycle 2, rsp_valid_o in cycle 3.
  - Store: rsp_valid_o in cycle 2.
- Legal funct3 codes:
  - Loads: 000 B, 001 H, 010 W, 100 BU, 101 HU. With XLEN=64, also 011 D and 110 WU.
  - Stores: 000, 001, 010, plus 011 when XLEN=64. All others are illegal.
- Size: 1, 2, 4 or 8 bytes. off = ea[OFFS_W-1:0]. Misaligned when off mod size != 0.
- mem_be_o = ((1<<size)-1) << off. For loads mem_be_o is the same pattern (informational).
- mem_wdata_o = the low size bytes of wdata replicated across all lanes.
- Load data = mem_rdata_i >> (8*off), truncated to size. Sign-extended for B/H/W/D; zero-extended for BU/HU/WU.
- A new request is accepted only in IDLE, so at most one access is outstanding.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses raise EXC with cause 0 (load) or 1 (store) and no memory access.
- Undefined: no misalignment trap. off is forced down to a multiple of size (low bits cleared) and the access proceeds normally. Illegal funct3 still traps.

Test Plan:
- LW, base=0x100, offset=4, rdata=0xDEADBEEF -> mem_addr_o=0x41, mem_be_o=0xF, rsp_valid_o in cycle 3, rsp_data_o=0xDEADBEEF, rsp_we_o=1.
- LB / LBU, ea=0x203, rdata=0x80112233 -> be=0x8; LB data=0xFFFFFF80, LBU data=0x00000080.
- SH, ea=0x102, wdata=0x0000ABCD -> mem_we_o=1, be=0xC, mem_wdata_o=0xABCDABCD, rsp_valid_o with rsp_we_o=0. mem_ready_i held low for 3 cycles -> mem_valid_o and all mem_* outputs stay stable.
- LW ea=0x101:
  - With LSU_MISALIGN_TRAP_EN: exc_valid_o=1, cause=0, exc_addr_o=0x101, mem_valid_o never rises.
  - Without the macro: access to word 0x40 with be=0xF.
- funct3=011 with XLEN=32 -> exc cause=2. With XLEN=64, SD at ea=0x8 -> be=0xFF, mem_addr_o=0x1.
- Load in WAIT, rst_n_i pulsed low, then mem_rvalid_i=1 -> outputs 0, req_ready_o=1, no rsp_valid_o.
